multi_edge_detector: RTL and testbench
======================================

# multi_edge_detector

Parametrised, multi-channel successor to the single-bit edge detector. Each of `WIDTH` asynchronous inputs is synchronised, optionally deglitched, and compared against its last accepted level. Qualifying rising/falling transitions then produce one-cycle pulses, a direction bit, sticky event flags and a shared saturating edge counter. The block sits between raw board/peripheral inputs and control logic that needs clean, countable events.

## Interface
- `WIDTH`, 4: number of independent input channels (1..32).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `FILTER_CYCLES`, 4: consecutive cycles a new level must persist before acceptance (≥1; used only with filter compiled in).
- `COUNT_W`, 16: width of edge counter.
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: synchronous, active-low; low on a rising `clk` edge resets the block.
- `signal_in` in WIDTH: asynchronous raw inputs.
- `mode` in 2: edge qualification: 00 none, 01 rising, 10 falling, 11 both.
- `flag_clr` in WIDTH: write-1-to-clear for `event_flag`, per bit, sampled each cycle.
- `count_clr` in 1: clears `edge_count`.
- `edge_pulse` out WIDTH: one-cycle pulse per qualifying edge.
- `edge_dir` out WIDTH: direction of the last accepted transition per channel (1 rising, 0 falling); valid while `edge_pulse[i]`=1, otherwise holds.
- `any_edge` out 1: OR of `edge_pulse`.
- `event_flag` out WIDTH: sticky per-channel qualifying-edge flag.
- `edge_count` out COUNT_W: saturating count of qualifying edges, summed over channels.

## Operation
- Per channel: `SYNC_STAGES` flop chain → filter → accepted-level register `lvl[i]`.
- Filter: counter `fc[i]` increments on each edge where sync output ≠ `lvl[i]`; resets to 0 on any edge where they match. On the edge where `fc[i]` would reach `FILTER_CYCLES`, `lvl[i]` takes the new value and `fc[i]` clears.
- Transition = `lvl[i]` update. A transition always updates `lvl[i]` and `edge_dir[i]`. `edge_pulse[i]` asserts only if `mode` enables that direction. `mode`=00 suppresses all pulses, flags and counting, but levels still track.
- Warm-up: after `reset` deasserts, a counter runs `SYNC_STAGES+FILTER_CYCLES` cycles. During warm-up, `lvl` loads the sync output directly and no pulses are produced. This prevents a spurious edge from an input that is already high.
- `event_flag[i]`: set on `edge_pulse[i]`, cleared by `flag_clr[i]`. If set and clear occur in the same cycle, set wins.
- `edge_count` += popcount(`edge_pulse`) each cycle, saturating at 2^COUNT_W−1. With `count_clr`, the count loads popcount of the same-cycle pulses.
- `mode` change takes effect on the next clock edge and never truncates a pulse already registered.

## Timing
- Reset values: all outputs 0; sync chains, `lvl`, `fc`, flags and count are 0; warm-up restarts.
- Reset mid-operation: in-flight filter counts are discarded and no pulse is emitted in the reset cycle or the cycle after.
- Latency: input stable before edge 0. Filter compiled in: `edge_pulse` high for the cycle after edge `SYNC_STAGES−1+FILTER_CYCLES`. Filter compiled out: high for the cycle after edge `SYNC_STAGES`.
- `edge_pulse` is exactly one cycle wide. Back-to-back accepted transitions on one channel are at least `FILTER_CYCLES` apart.
- `event_flag` and `edge_count` update on the same edge as `edge_pulse` rises (visible in the same cycle).

## Configuration
- `MULTI_EDGE_DET_FILTER_EN` defined: the glitch filter and `fc` counters are present, and `FILTER_CYCLES` applies.
- Not defined: `lvl[i]` loads the sync output whenever it differs (equivalent to `FILTER_CYCLES`=1). No filter counters are synthesised, and warm-up is `SYNC_STAGES+1` cycles.

## Structure
- Package `edge_det_pkg`: `mode` encoding constants (`MODE_NONE`, `MODE_RISE`, `MODE_FALL`, `MODE_BOTH`) and a popcount function.
- Sub-module `edge_det_channel`: sync chain, filter, `lvl`, direction and qualified pulse for one bit, instantiated WIDTH times via generate. The top level holds warm-up, flags and the counter.

## Test plan
- Defaults, filter on, `mode`=01: `signal_in[0]` 0→1 before edge 10 → `edge_pulse[0]`=1 only in the cycle after edge 15, `edge_dir[0]`=1, `event_flag[0]`=1, `edge_count`=1.
- Filter on: a 3-cycle high glitch on ch1 → no pulse, count unchanged. A 4-cycle high → exactly one rising pulse.
- `mode`=11, ch0 and ch2 toggle in the same cycle → both pulses together, `any_edge`=1, `edge_count` += 2. `mode`=10 → only falling transitions pulse.
- `signal_in`=4'hF through reset release → zero pulses after warm-up, `lvl`=F. Assert `reset` mid-filter → no pulse, all outputs 0.
- `COUNT_W`=4: 20 edges → `edge_count`=15 (saturated). `flag_clr[0]`=1 coinciding with a ch0 pulse → flag stays 1. `count_clr` together with 1 pulse → count=1.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   MODE_* : encodings of the 2-bit edge-qualification mode.
//   popcount(): number of set bits in a 32-bit vector.
package edge_det_pkg;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One input channel: synchroniser, optional glitch filter, accepted level, direction, qualified pulse.
// Latency: pulse registered on edge SYNC_STAGES-1+FILTER_CYCLES (filter in) or SYNC_STAGES (filter out).
// Backpressure: none; pulses are fire-and-forget.
//
// Build option: MULTI_EDGE_DET_FILTER_EN adds the persistence filter (FILTER_CYCLES parameter).
// Ports: clk, reset (sync, active-low), warm (warm-up in progress), mode, sig_in (async raw input),
//        pulse_d (pulse about to be registered), pulse_q (registered pulse), dir_q (last accepted direction).
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES   = 2
`ifdef MULTI_EDGE_DET_FILTER_EN
    ,
    parameter int FILTER_CYCLES = 4
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       warm,
    input  logic [1:0] mode,
    input  logic       sig_in,
    output logic       pulse_d,
    output logic       pulse_q,
    output logic       dir_q
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   lvl_d, lvl_q;
    logic                   dir_d;
    logic                   sync_out;
    logic                   xfer;
    logic                   rise_ok, fall_ok;

`ifdef MULTI_EDGE_DET_FILTER_EN
    localparam int              FC_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);
    logic [FC_W-1:0] fc_d, fc_q;
`endif

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
        sync_out = sync_q[SYNC_STAGES-1];
        lvl_d    = lvl_q;
        xfer     = 1'b0;
`ifdef MULTI_EDGE_DET_FILTER_EN
        fc_d     = '0;
        if (warm) begin
            // Adopt whatever the pin shows so a line already high never looks like an edge.
            lvl_d = sync_out;
        end else if (sync_out != lvl_q) begin
            // The cycle that would bring the run length to FILTER_CYCLES accepts the level.
            if (fc_q == FC_LAST) begin
                lvl_d = sync_out;
                xfer  = 1'b1;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
        end
`else
        if (warm) begin
            lvl_d = sync_out;
        end else if (sync_out != lvl_q) begin
            lvl_d = sync_out;
            xfer  = 1'b1;
        end
`endif
        dir_d = xfer ? sync_out : dir_q;

        rise_ok = 1'b0;
        fall_ok = 1'b0;
        case (mode)
            MODE_NONE: begin rise_ok = 1'b0; fall_ok = 1'b0; end
            MODE_RISE: rise_ok = 1'b1;
            MODE_FALL: fall_ok = 1'b1;
            MODE_BOTH: begin rise_ok = 1'b1; fall_ok = 1'b1; end
            default:   begin rise_ok = 1'b0; fall_ok = 1'b0; end
        endcase
        pulse_d = xfer && (sync_out ? rise_ok : fall_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            lvl_q   <= 1'b0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
`ifdef MULTI_EDGE_DET_FILTER_EN
            fc_q    <= '0;
`endif
        end else begin
            sync_q  <= sync_d;
            lvl_q   <= lvl_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
`ifdef MULTI_EDGE_DET_FILTER_EN
            fc_q    <= fc_d;
`endif
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel pulses/direction, sticky flags, shared saturating edge count.
// Latency: pulse visible after edge SYNC_STAGES-1+FILTER_CYCLES (filter in) or SYNC_STAGES (filter out); flags/count same edge.
// Backpressure: none; events are never stalled, the counter saturates instead of wrapping.
//
// Build option: MULTI_EDGE_DET_FILTER_EN compiles in the per-channel glitch filter.
// Ports: clk, reset (sync active-low), signal_in[WIDTH] (async), mode (00 none/01 rise/10 fall/11 both),
//        flag_clr[WIDTH] (W1C), count_clr, edge_pulse, edge_dir, any_edge, event_flag, edge_count[COUNT_W].
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   signal_in,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   flag_clr,
    input  logic               count_clr,
    output logic [WIDTH-1:0]   edge_pulse,
    output logic [WIDTH-1:0]   edge_dir,
    output logic               any_edge,
    output logic [WIDTH-1:0]   event_flag,
    output logic [COUNT_W-1:0] edge_count
);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || FILTER_CYCLES < 1 || COUNT_W < 1) begin : g_bad_cfg
        $error("multi_edge_detector: parameter out of range");
    end

`ifdef MULTI_EDGE_DET_FILTER_EN
    localparam int WARM = SYNC_STAGES + FILTER_CYCLES;
`else
    localparam int WARM = SYNC_STAGES + 1;
`endif
    localparam int              WU_W   = $clog2(WARM + 1);
    localparam logic [WU_W-1:0] WU_END = WU_W'(WARM);

    // Six spare bits hold a full 32-channel popcount, so the sum never wraps before saturation.
    localparam int               SUM_W   = COUNT_W + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = {6'd0, {COUNT_W{1'b1}}};

    logic [WU_W-1:0]    wu_d, wu_q;
    logic               warm;
    logic [WIDTH-1:0]   pulse_d, pulse_q, dir_q;
    logic [WIDTH-1:0]   flag_d, flag_q;
    logic [COUNT_W-1:0] count_d, count_q;
    logic [5:0]         pc;
    logic [SUM_W-1:0]   base, sum;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        edge_det_channel #(
            .SYNC_STAGES   (SYNC_STAGES)
`ifdef MULTI_EDGE_DET_FILTER_EN
            ,
            .FILTER_CYCLES (FILTER_CYCLES)
`endif
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .warm    (warm),
            .mode    (mode),
            .sig_in  (signal_in[i]),
            .pulse_d (pulse_d[i]),
            .pulse_q (pulse_q[i]),
            .dir_q   (dir_q[i])
        );
    end

    always_comb begin
        // Warm-up counter sits at 0 through reset, so warm-up restarts on every release.
        warm = (wu_q != WU_END);
        wu_d = warm ? wu_q + WU_W'(1) : wu_q;

        // Set beats clear when both hit the same bit in one cycle.
        flag_d = (flag_q & ~flag_clr) | pulse_d;

        // Flags and count use next-cycle pulses so they change on the same edge as edge_pulse.
        pc      = popcount(32'(pulse_d));
        base    = count_clr ? '0 : {6'd0, count_q};
        sum     = base + {{(SUM_W-6){1'b0}}, pc};
        count_d = (sum > CNT_MAX) ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wu_q    <= '0;
            flag_q  <= '0;
            count_q <= '0;
        end else begin
            wu_q    <= wu_d;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    assign edge_pulse = pulse_q;
    assign edge_dir   = dir_q;
    assign any_edge   = |pulse_q;
    assign event_flag = flag_q;
    assign edge_count = count_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
module tb_multi_edge_detector;

    localparam int SYNC = 2;
`ifdef MULTI_EDGE_DET_FILTER_EN
    localparam int FILT = 4;
`else
    localparam int FILT = 1;
`endif
    localparam int LAT  = SYNC - 1 + FILT;
    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  signal_in;
    logic [1:0]  mode;
    logic [3:0]  flag_clr;
    logic        count_clr;
    logic [3:0]  edge_pulse, edge_dir, event_flag;
    logic        any_edge;
    logic [15:0] edge_count;
    logic [3:0]  edge_pulse4, edge_dir4, event_flag4;
    logic        any_edge4;
    logic [3:0]  edge_count4;

    always #5 clk = ~clk;

    multi_edge_detector #(.WIDTH(4), .SYNC_STAGES(SYNC), .FILTER_CYCLES(4), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset), .signal_in(signal_in), .mode(mode), .flag_clr(flag_clr),
        .count_clr(count_clr), .edge_pulse(edge_pulse), .edge_dir(edge_dir), .any_edge(any_edge),
        .event_flag(event_flag), .edge_count(edge_count)
    );

    multi_edge_detector #(.WIDTH(4), .SYNC_STAGES(SYNC), .FILTER_CYCLES(4), .COUNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .signal_in(signal_in), .mode(mode), .flag_clr(flag_clr),
        .count_clr(count_clr), .edge_pulse(edge_pulse4), .edge_dir(edge_dir4), .any_edge(any_edge4),
        .event_flag(event_flag4), .edge_count(edge_count4)
    );

    typedef struct {
        logic [3:0] sig;
        logic [1:0] mode;
        logic [3:0] pulse;
        logic [3:0] dir;
        logic [3:0] flag;
        int         count;
    } vec_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt;
    int   npulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          sig    mode   pulse  dir    flag   count
        vecs[0] = '{4'h1, 2'b01, 4'h1, 4'h1, 4'h1, 1};
        vecs[1] = '{4'h0, 2'b01, 4'h0, 4'h0, 4'h1, 1};
        vecs[2] = '{4'h5, 2'b11, 4'h5, 4'h5, 4'h5, 3};
        vecs[3] = '{4'h0, 2'b10, 4'h5, 4'h0, 4'h5, 5};
        vecs[4] = '{4'h8, 2'b10, 4'h0, 4'h8, 4'h5, 5};
        vecs[5] = '{4'h0, 2'b00, 4'h0, 4'h0, 4'h5, 5};
        vecs[6] = '{4'h2, 2'b00, 4'h0, 4'h2, 4'h5, 5};
        vecs[7] = '{4'hA, 2'b11, 4'h8, 4'hA, 4'hD, 6};
        vecs[8] = '{4'h3, 2'b11, 4'h9, 4'h3, 4'hD, 8};

        reset = 1'b0; signal_in = 4'h0; mode = 2'b01; flag_clr = 4'h0; count_clr = 1'b0;
        #1;
        tick(); tick();
        check("rst_pulse", edge_pulse, 0);
        check("rst_any", any_edge, 0);
        check("rst_dir", edge_dir, 0);
        check("rst_flag", event_flag, 0);
        check("rst_count", edge_count, 0);
        check("rst_count4", edge_count4, 0);
        reset = 1'b1;
        repeat (12) tick();
        check("warm_quiet", edge_pulse, 0);

        // Table: each record holds its input for HOLD cycles; the pulse must land exactly LAT edges in.
        for (int v = 0; v < 9; v++) begin
            signal_in = vecs[v].sig;
            mode      = vecs[v].mode;
            for (int j = 0; j < HOLD; j++) begin
                tick();
                check($sformatf("vec%0d_pulse_c%0d", v, j), edge_pulse, (j == LAT) ? vecs[v].pulse : 4'h0);
                if (j == LAT) check($sformatf("vec%0d_any", v), any_edge, (vecs[v].pulse != 4'h0));
            end
            check($sformatf("vec%0d_dir", v), edge_dir, vecs[v].dir);
            check($sformatf("vec%0d_flag", v), event_flag, vecs[v].flag);
            check($sformatf("vec%0d_count", v), edge_count, vecs[v].count);
            check($sformatf("vec%0d_count4", v), edge_count4, (vecs[v].count > 15) ? 15 : vecs[v].count);
        end

        // Plain clears.
        flag_clr = 4'hF; tick(); flag_clr = 4'h0;
        check("flag_clr_all", event_flag, 0);
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        check("count_clr_idle", edge_count, 0);

        // flag_clr coinciding with a ch0 falling pulse: set wins.
        signal_in = 4'h2;
        repeat (LAT) tick();
        flag_clr = 4'h1;
        tick();
        check("w1c_pulse", edge_pulse, 4'h1);
        check("w1c_flag_kept", event_flag, 4'h1);
        check("w1c_dir", edge_dir, 4'h2);
        tick();
        flag_clr = 4'h0;
        check("w1c_flag_cleared", event_flag, 4'h0);

        // count_clr coinciding with a ch0 rising pulse: count loads 1.
        signal_in = 4'h3;
        repeat (LAT) tick();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        check("cclr_pulse", edge_pulse, 4'h1);
        check("cclr_count", edge_count, 1);
        check("cclr_dir", edge_dir, 4'h3);
        repeat (HOLD) tick();

        // Glitches on ch1: only runs of at least FILT cycles are accepted.
        mode = 2'b00; signal_in = 4'h0;
        repeat (HOLD) tick();
        mode = 2'b01;
        exp_cnt = 1;
        for (int g = 3; g <= 4; g++) begin
            npulse = 0;
            signal_in = 4'h2;
            for (int j = 0; j < g; j++) begin
                tick();
                npulse += int'(edge_pulse[1]);
            end
            signal_in = 4'h0;
            for (int j = 0; j < 16; j++) begin
                tick();
                npulse += int'(edge_pulse[1]);
            end
            exp_cnt += (g >= FILT) ? 1 : 0;
            check($sformatf("glitch%0d_pulses", g), npulse, (g >= FILT) ? 1 : 0);
            check($sformatf("glitch%0d_count", g), edge_count, exp_cnt);
        end

        // Saturation: 20 edges on the 4-bit counter.
        count_clr = 1'b1; tick(); count_clr = 1'b0;
        check("sat_clr", edge_count, 0);
        check("sat_clr4", edge_count4, 0);
        mode = 2'b11;
        for (int k = 0; k < 5; k++) begin
            signal_in = (k % 2 == 0) ? 4'hF : 4'h0;
            repeat (HOLD) tick();
            check($sformatf("sat_count_%0d", k), edge_count, 4 * (k + 1));
            check($sformatf("sat_count4_%0d", k), edge_count4, (4 * (k + 1) > 15) ? 15 : 4 * (k + 1));
        end

        // Inputs high through reset: no pulses, levels already F afterwards.
        reset = 1'b0;
        tick();
        check("rstF_pulse", edge_pulse, 0);
        check("rstF_any", any_edge, 0);
        check("rstF_flag", event_flag, 0);
        check("rstF_count", edge_count, 0);
        check("rstF_dir", edge_dir, 0);
        tick();
        reset = 1'b1;
        npulse = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            npulse += (edge_pulse != 4'h0) ? 1 : 0;
        end
        check("rstF_no_pulse", npulse, 0);
        mode = 2'b10;
        signal_in = 4'h0;
        for (int j = 0; j < HOLD; j++) begin
            tick();
            check($sformatf("rstF_fall_c%0d", j), edge_pulse, (j == LAT) ? 4'hF : 4'h0);
        end
        check("rstF_fall_count", edge_count, 4);
        check("rstF_fall_dir", edge_dir, 0);

        // Reset asserted while a rising edge is in flight.
        mode = 2'b11;
        signal_in = 4'h1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rstmid_pulse", edge_pulse, 0);
        check("rstmid_any", any_edge, 0);
        check("rstmid_flag", event_flag, 0);
        check("rstmid_count", edge_count, 0);
        tick();
        check("rstmid_pulse2", edge_pulse, 0);
        reset = 1'b1;
        npulse = 0;
        for (int j = 0; j < 20; j++) begin
            tick();
            npulse += (edge_pulse != 4'h0) ? 1 : 0;
        end
        check("rstmid_no_pulse", npulse, 0);
        check("rstmid_count_after", edge_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
